// File: rtl/seq_decoder.sv
// seq_decoder
//   Registered code decoder with a built-in index scanner.
//   Depending on mode it does one of four things. It decodes an incoming code
//   into a one-hot word. It decodes the code into a thermometer word. It steps
//   a one-hot output through every index, dwelling DWELL cycles on each. Or it
//   freezes everything.
//
// Parameters
//   WIDTH  code width (1..6); the output word is 2**WIDTH bits
//   DWELL  clock cycles spent on each index while scanning (1..255)
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   en         global enable; 0 freezes all state
//   mode       00 one-hot, 01 thermometer, 10 auto-scan, 11 hold
//   in         code to decode
//   in_valid   in carries a code this cycle
//   in_ready   combinational: block accepts in this cycle
//   out        registered decoded word
//   out_valid  one-cycle pulse: out updated on this edge
//   scan_idx   current scan index
//   wrap       one-cycle pulse: scan index wrapped back to 0
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | after reset, nothing has happened yet
// ST_DEC   | decoding codes offered on in/in_valid (one-hot or thermometer)
// ST_SCAN  | auto-scanning; out walks a single one across all indices
// ST_HOLD  | out, scan_idx and dwell count frozen; no pulses

module seq_decoder #(
  parameter int WIDTH = 4,
  parameter int DWELL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2**WIDTH-1:0]   out,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      scan_idx,
  output logic                  wrap
);

  localparam int               OUT_W      = 2**WIDTH;
  localparam logic [WIDTH-1:0] IDX_LAST   = '1;
  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);

  localparam logic [1:0] MODE_ONEHOT = 2'b00;
  localparam logic [1:0] MODE_THERMO = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEC  = 2'd1,
    ST_SCAN = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t           state;
  logic [7:0]       dwell_cnt;
  logic [WIDTH-1:0] next_idx;
  logic             accept;

  function automatic logic [OUT_W-1:0] onehot(input logic [WIDTH-1:0] code);
    logic [OUT_W-1:0] w;
    w       = '0;
    w[code] = 1'b1;
    return w;
  endfunction

  // Bits 0..code set. Built bit by bit so code = all-ones needs no
  // shift past the word width.
  function automatic logic [OUT_W-1:0] thermo(input logic [WIDTH-1:0] code);
    logic [OUT_W-1:0] w;
    w = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (i <= int'(code)) w[i] = 1'b1;
    end
    return w;
  endfunction

  // Ready depends only on the mode presented this cycle, so a code offered
  // in the same cycle the mode switches into a decode mode is taken.
  assign in_ready = rst_n & en & ~mode[1];
  assign accept   = in_valid & in_ready;
  assign next_idx = scan_idx + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      scan_idx  <= '0;
      wrap      <= 1'b0;
      dwell_cnt <= '0;
    end else if (!en) begin
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      case (mode)
        MODE_ONEHOT, MODE_THERMO: begin
          state <= ST_DEC;
          if (accept) begin
            out       <= (mode == MODE_ONEHOT) ? onehot(in) : thermo(in);
            out_valid <= 1'b1;
          end
        end
        MODE_SCAN: begin
          state <= ST_SCAN;
          if (state != ST_SCAN) begin
            // Fresh entry always restarts at index 0; this is not a wrap.
            scan_idx  <= '0;
            dwell_cnt <= '0;
            out       <= onehot('0);
            out_valid <= 1'b1;
          end else if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            scan_idx  <= next_idx;
            out       <= onehot(next_idx);
            out_valid <= 1'b1;
            wrap      <= (scan_idx == IDX_LAST);
          end else begin
            dwell_cnt <= dwell_cnt + 8'd1;
          end
        end
        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end

endmodule
